// File: rtl/imm_instr_encoder.sv
// Packs lw/sw/beq fields plus a signed immediate into RV32I words and streams them to instruction memory.
// One-cycle accept-to-write latency; the output register holds while mem_busy is high and in_ready drops.
module imm_instr_encoder #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 64,
  parameter logic [WIDTH-1:0] BASE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             mem_busy,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);

  localparam logic [1:0] OP_LW  = 2'b00;
  localparam logic [1:0] OP_SW  = 2'b01;
  localparam logic [1:0] OP_BEQ = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            out_valid;
  logic [CW-1:0]   accepted;
  logic [CW-1:0]   written;
  logic            imm_ok;
  logic            req_good;
  logic            accept;
  logic [31:0]     enc_word;

  // beq takes the immediate in the extender's native units: field bit i carries imm[i], no shift.
  function automatic logic [31:0] encode(
    input logic [1:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (op)
      OP_LW:   w = {imm, rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BEQ:  w = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign imm_ok   = (in_imm == {{(WIDTH-12){in_imm[11]}}, in_imm[11:0]});
  assign req_good = (in_op != OP_BAD) && imm_ok;
  assign enc_word = encode(in_op, in_rd, in_rs1, in_rs2, in_imm[11:0]);

  assign in_ready = (state == S_LOAD) && (accepted < DEPTH_C) && (!out_valid || !mem_busy);
  assign wr_en    = out_valid && !mem_busy;
  assign accept   = in_valid && in_ready && !clear;
  assign full     = (state == S_FULL);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  if (wr_en && (written == LAST_C)) next_state = S_FULL;
      default: next_state = state;
    endcase
    if (clear) next_state = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= BASE;
      accepted  <= '0;
      written   <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= BASE;
      accepted  <= '0;
      written   <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      if (wr_en) begin
        wr_addr <= wr_addr + WIDTH'(4);
        written <= written + CW'(1);
      end
      // A same-edge accept refills the register the write just drained.
      if (accept && req_good) begin
        wr_data   <= WIDTH'(enc_word);
        out_valid <= 1'b1;
        accepted  <= accepted + CW'(1);
      end else if (wr_en) begin
        out_valid <= 1'b0;
      end
      if (accept && !req_good) begin
        err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
